// File: rtl/fpu_sqrt_pkg.sv
// Shared widths, FSM state type and radicand alignment helper for the
// iterative significand square-root unit.
package fpu_sqrt_pkg;

  localparam int unsigned SQRT_MANT_W = 24;
  localparam int unsigned SQRT_ROOT_W = 26;
  localparam int unsigned SQRT_REM_W  = 28;
  localparam int unsigned SQRT_RAD_W  = 52;
  localparam int unsigned SQRT_X_W    = SQRT_MANT_W + 1;
  localparam int unsigned SQRT_LGRS_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sqrt_state_e;

  // Two integer bits: an odd exponent pre-doubles the significand.
  function automatic logic [SQRT_RAD_W-1:0] sqrt_radicand(
    input logic [SQRT_MANT_W-1:0] mant,
    input logic                   exp_odd
  );
    logic [SQRT_X_W-1:0] x;
    x = exp_odd ? {mant, 1'b0} : {1'b0, mant};
    return {x, {(SQRT_RAD_W - SQRT_X_W){1'b0}}};
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root step: bring down two radicand
// bits, try subtracting {root,01}, and shift the resulting root bit in.
module sqrt_step
  import fpu_sqrt_pkg::*;
(
  input  logic [SQRT_REM_W-1:0]  rem,
  input  logic [SQRT_ROOT_W-1:0] acc,
  input  logic [1:0]             bits,
  output logic [SQRT_REM_W-1:0]  next_rem,
  output logic [SQRT_ROOT_W-1:0] next_acc
);

  localparam int unsigned EXT_W = SQRT_REM_W + 2;

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] trial;
  logic             fits;

  // The remainder never exceeds 2*root, so the top bits dropped on truncation are zero.
  always_comb begin
    shifted  = {rem, bits};
    trial    = EXT_W'({acc, 2'b01});
    fits     = (shifted >= trial);
    next_rem = fits ? SQRT_REM_W'(shifted - trial) : SQRT_REM_W'(shifted);
    next_acc = {acc[SQRT_ROOT_W-2:0], fits};
  end

endmodule

// File: rtl/sqrt_mantissa_iter.sv
// Iterative restoring square root of a 24-bit significand with LGRS output.
// Define SQRT_MANT_TWO_STEP_EN to retire two root bits per clock (13-cycle latency).
module sqrt_mantissa_iter
  import fpu_sqrt_pkg::*;
#(
  parameter int unsigned ITERS = 26
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   kill_i,
  input  logic [SQRT_MANT_W-1:0] mant_i,
  input  logic                   exp_odd_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SQRT_MANT_W-1:0] root_o,
  output logic [SQRT_LGRS_W-1:0] lgrs_o
);

`ifdef SQRT_MANT_TWO_STEP_EN
  localparam int unsigned STEPS = 2;
`else
  localparam int unsigned STEPS = 1;
`endif
  localparam int unsigned CNT_W     = $clog2(ITERS + 1);
  localparam int unsigned CNT_INIT  = ITERS / STEPS;
  localparam int unsigned RAD_SHIFT = 2 * STEPS;

  sqrt_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SQRT_RAD_W-1:0]   rad_q, rad_d;
  logic [SQRT_REM_W-1:0]   rem_q, rem_d;
  logic [SQRT_ROOT_W-1:0]  acc_q, acc_d;
  logic                    busy_d, done_d;
  logic [SQRT_MANT_W-1:0]  root_d;
  logic [SQRT_LGRS_W-1:0]  lgrs_d;

  logic [SQRT_REM_W-1:0]   rem_s1, step_rem;
  logic [SQRT_ROOT_W-1:0]  acc_s1, step_acc;

  sqrt_step u_step0 (
    .rem      (rem_q),
    .acc      (acc_q),
    .bits     (rad_q[SQRT_RAD_W-1 -: 2]),
    .next_rem (rem_s1),
    .next_acc (acc_s1)
  );

`ifdef SQRT_MANT_TWO_STEP_EN
  sqrt_step u_step1 (
    .rem      (rem_s1),
    .acc      (acc_s1),
    .bits     (rad_q[SQRT_RAD_W-3 -: 2]),
    .next_rem (step_rem),
    .next_acc (step_acc)
  );
`else
  assign step_rem = rem_s1;
  assign step_acc = acc_s1;
`endif

  // Next-state and datapath update; kill wins over both start and stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    root_d  = root_o;
    lgrs_d  = lgrs_o;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          state_d = RUN;
          rad_d   = sqrt_radicand(mant_i, exp_odd_i);
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = CNT_W'(CNT_INIT);
        end
      end
      RUN: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          rad_d = rad_q << RAD_SHIFT;
          rem_d = step_rem;
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            root_d  = step_acc[SQRT_ROOT_W-1:2];
            lgrs_d  = {step_acc[2], step_acc[1], step_acc[0], |step_rem};
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      root_o  <= '0;
      lgrs_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      root_o  <= root_d;
      lgrs_o  <= lgrs_d;
    end
  end

endmodule

// File: tb/tb_sqrt_mantissa_iter.sv
// Self-checking bench for sqrt_mantissa_iter: fixed vector table, kill/reset/
// back-to-back sequences and a random sweep against an integer-sqrt model.
module tb_sqrt_mantissa_iter;

`ifdef SQRT_MANT_TWO_STEP_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 26;
`endif
  localparam int N_RAND = 1500;

  logic        clk_i;
  logic        reset_i;
  logic        start_i;
  logic        kill_i;
  logic [23:0] mant_i;
  logic        exp_odd_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] root_o;
  logic [3:0]  lgrs_o;

  sqrt_mantissa_iter dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .kill_i    (kill_i),
    .mant_i    (mant_i),
    .exp_odd_i (exp_odd_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .root_o    (root_o),
    .lgrs_o    (lgrs_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] root;
    logic [3:0]  lgrs;
  } exp_t;

  typedef struct {
    logic [23:0] mant;
    logic        odd;
    logic [23:0] root;
    logic [3:0]  lgrs;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Reference: floor(sqrt(X * 2^27)) found by refining a floating-point estimate.
  function automatic exp_t ref_sqrt(input logic [23:0] m, input logic odd);
    longint unsigned x, n, q;
    exp_t r;
    x = odd ? (64'(m) << 1) : 64'(m);
    n = x << 27;
    q = 64'($rtoi($sqrt(real'(n))));
    while (q * q > n) q = q - 1;
    while ((q + 1) * (q + 1) <= n) q = q + 1;
    r.root = q[25:2];
    r.lgrs = {q[2], q[1], q[0], (q * q != n)};
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (reset_i && done_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done_o), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("root", 32'(root_o), 32'(mon_e.root));
        check("lgrs", 32'(lgrs_o), 32'(mon_e.lgrs));
      end
    end
  end

  task automatic launch(input logic [23:0] m, input logic odd);
    @(negedge clk_i);
    start_i   = 1'b1;
    mant_i    = m;
    exp_odd_i = odd;
    @(posedge clk_i);
    #1;
    start_i   = 1'b0;
    mant_i    = ~m;
    exp_odd_i = ~odd;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk_i);
      lat++;
      #1;
    end while (!done_o && lat < LAT + 8);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    int          lat;
    logic [23:0] m;
    logic        odd;
    exp_t        e;

    vecs[0] = '{mant: 24'h800000, odd: 1'b0, root: 24'h800000, lgrs: 4'b0000};
    vecs[1] = '{mant: 24'h800000, odd: 1'b1, root: 24'hB504F3, lgrs: 4'b1001};
    vecs[2] = '{mant: 24'h900000, odd: 1'b1, root: 24'hC00000, lgrs: 4'b0000};
    vecs[3] = '{mant: 24'h000000, odd: 1'b0, root: 24'h000000, lgrs: 4'b0000};
    vecs[4] = '{mant: 24'hC80000, odd: 1'b0, root: 24'hA00000, lgrs: 4'b0000};
    vecs[5] = '{mant: 24'hC40000, odd: 1'b1, root: 24'hE00000, lgrs: 4'b0000};

    reset_i = 1'b0; start_i = 1'b0; kill_i = 1'b0; mant_i = '0; exp_odd_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_done", 32'(done_o), 32'(0));
    check("rst_root", 32'(root_o), 32'(0));
    check("rst_lgrs", 32'(lgrs_o), 32'(0));
    @(negedge clk_i);
    reset_i = 1'b1;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{root: vecs[i].root, lgrs: vecs[i].lgrs});
      launch(vecs[i].mant, vecs[i].odd);
      check("busy_after_accept", 32'(busy_o), 32'(1));
      wait_done(lat);
      check("latency", 32'(lat), 32'(LAT));
      check("busy_at_done", 32'(busy_o), 32'(0));
    end

    // Kill mid-operation: no result, outputs keep last root
    launch(24'h800000, 1'b1);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    check("kill_busy", 32'(busy_o), 32'(0));
    check("kill_done", 32'(done_o), 32'(0));
    check("kill_root_hold", 32'(root_o), 32'(24'hE00000));
    sb.push_back('{root: 24'h800000, lgrs: 4'b0000});
    launch(24'h800000, 1'b0);
    wait_done(lat);
    check("restart_latency", 32'(lat), 32'(LAT));

    // Kill beats start while idle
    @(negedge clk_i);
    start_i = 1'b1; kill_i = 1'b1; mant_i = 24'h900000; exp_odd_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("kill_start_busy", 32'(busy_o), 32'(0));
    repeat (LAT + 3) @(posedge clk_i);

    // Start held high: second operand ignored, start in done cycle accepted
    sb.push_back('{root: 24'hC00000, lgrs: 4'b0000});
    @(negedge clk_i);
    start_i = 1'b1; mant_i = 24'h900000; exp_odd_i = 1'b1;
    @(posedge clk_i);
    #1;
    mant_i = 24'h800000; exp_odd_i = 1'b1;
    wait_done(lat);
    check("held_latency", 32'(lat), 32'(LAT));
    mant_i = 24'hC80000; exp_odd_i = 1'b0;
    sb.push_back('{root: 24'hA00000, lgrs: 4'b0000});
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check("b2b_busy", 32'(busy_o), 32'(1));
    wait_done(lat);
    check("b2b_latency", 32'(lat), 32'(LAT));

    // Async reset mid-operation clears outputs without waiting for an edge
    launch(24'h800000, 1'b1);
    repeat (4) @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    #1;
    check("areset_busy", 32'(busy_o), 32'(0));
    check("areset_done", 32'(done_o), 32'(0));
    check("areset_root", 32'(root_o), 32'(0));
    check("areset_lgrs", 32'(lgrs_o), 32'(0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (LAT + 3) @(posedge clk_i);

    // Random sweep with a few fixed corners first
    for (int i = 0; i < N_RAND; i++) begin
      case (i)
        0: begin m = 24'hFFFFFF; odd = 1'b1; end
        1: begin m = 24'hFFFFFF; odd = 1'b0; end
        2: begin m = 24'h800001; odd = 1'b0; end
        3: begin m = 24'h800001; odd = 1'b1; end
        default: begin
          m   = 24'($urandom);
          odd = 1'($urandom);
          if ($urandom_range(3) != 0) m[23] = 1'b1;
        end
      endcase
      e = ref_sqrt(m, odd);
      sb.push_back(e);
      launch(m, odd);
      wait_done(lat);
      if (i % 100 == 0) check("rand_latency", 32'(lat), 32'(LAT));
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
